// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions.
//   stuff_state_t : bit-stuffer FSM states
//   USB_STUFF_LEN : run of consecutive 1s after which a 0 is inserted
//   USB_CNT_W     : default width of the stuffed-bit statistics counter
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2
  } stuff_state_t;

  localparam int USB_STUFF_LEN = 6;
  localparam int USB_CNT_W     = 8;

endpackage

// File: rtl/bit_stuff_if.sv
// Serial packet link through the bit stuffer.
// Upstream side (CRC stage): s_in, start_b, endr_b in; pause back.
// Downstream side (NRZI):    s_out, start_s, endr_s out; busy and
//                            stuff_cnt are status.
//   master : the environment around the stuffer (drives s_in/start_b/endr_b)
//   slave  : the stuffer itself
interface bit_stuff_if #(
  parameter int CNT_W = 8
);
  logic             s_in;
  logic             start_b;
  logic             endr_b;
  logic             pause;
  logic             s_out;
  logic             start_s;
  logic             endr_s;
  logic             busy;
  logic [CNT_W-1:0] stuff_cnt;

  modport master (
    output s_in, start_b, endr_b,
    input  pause, s_out, start_s, endr_s, busy, stuff_cnt
  );

  modport slave (
    input  s_in, start_b, endr_b,
    output pause, s_out, start_s, endr_s, busy, stuff_cnt
  );
endinterface

// File: rtl/bit_stuff.sv
// USB bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s of the
// serial packet stream. Each inserted bit costs one STUFF cycle during which
// pause is high so upstream holds its current bit/strobe.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bit_stuff_if slave (s_in/start_b/endr_b in, pause/s_out/
//          start_s/endr_s/busy/stuff_cnt out)
// All outputs are registered; the output stream is the input delayed by one
// cycle with stuffed zeros spliced in.
module bit_stuff
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int CNT_W     = USB_CNT_W
) (
  input logic        clk,
  input logic        rst,
  bit_stuff_if.slave bus
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  stuff_state_t     state_reg;
  logic [RUN_W-1:0] run_cnt_reg;
  logic [CNT_W-1:0] stuff_cnt_reg;
  logic             s_out_reg;
  logic             start_s_reg;
  logic             endr_s_reg;
  logic             busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      run_cnt_reg   <= '0;
      stuff_cnt_reg <= '0;
      s_out_reg     <= 1'b0;
      start_s_reg   <= 1'b0;
      endr_s_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      // framing strobes are single-cycle pulses
      start_s_reg <= 1'b0;
      endr_s_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          s_out_reg <= 1'b0;
          if (bus.start_b) begin
            state_reg     <= RUN;
            start_s_reg   <= 1'b1;
            run_cnt_reg   <= '0;
            stuff_cnt_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end

        RUN: begin
          if (bus.start_b) begin
            // restart: the current packet is dropped without an end strobe;
            // start_b has priority over a coincident endr_b
            start_s_reg   <= 1'b1;
            run_cnt_reg   <= '0;
            stuff_cnt_reg <= '0;
            s_out_reg     <= 1'b0;
            busy_reg      <= 1'b1;
          end else if (bus.endr_b) begin
            state_reg   <= IDLE;
            endr_s_reg  <= 1'b1;
            busy_reg    <= 1'b0;
            s_out_reg   <= 1'b0;
            run_cnt_reg <= '0;
          end else begin
            s_out_reg <= bus.s_in;
            if (!bus.s_in) begin
              run_cnt_reg <= '0;
            end else if (run_cnt_reg == RUN_W'(STUFF_LEN - 1)) begin
              // this bit completes the run; the next cycle carries the 0
              state_reg   <= STUFF;
              run_cnt_reg <= '0;
            end else begin
              run_cnt_reg <= run_cnt_reg + 1'b1;
            end
          end
        end

        STUFF: begin
          // upstream is paused, so its inputs are not consumed here
          s_out_reg <= 1'b0;
          state_reg <= RUN;
          if (stuff_cnt_reg != '1) begin
            stuff_cnt_reg <= stuff_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          s_out_reg   <= 1'b0;
          busy_reg    <= 1'b0;
          run_cnt_reg <= '0;
        end
      endcase
    end
  end

  // state_reg is a flop, so pause is glitch-free and effectively registered
  assign bus.pause     = (state_reg == STUFF);
  assign bus.s_out     = s_out_reg;
  assign bus.start_s   = start_s_reg;
  assign bus.endr_s    = endr_s_reg;
  assign bus.busy      = busy_reg;
  assign bus.stuff_cnt = stuff_cnt_reg;

endmodule

// File: tb/tb_bit_stuff.sv
// Directed testbench for bit_stuff. Each step presents one upstream item
// (bit or strobe), holding it while pause is high, and logs every output
// cycle into shift registers that are compared with hand-computed vectors.
module tb_bit_stuff;

  localparam int CNT_W = 8;

  logic clk;
  logic rst;

  bit_stuff_if #(.CNT_W(CNT_W)) bus ();

  bit_stuff #(.STUFF_LEN(6), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] obs_out;
  logic [63:0] obs_p;
  logic [63:0] obs_e;
  int          n_cyc;
  int          n_start;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clr();
    obs_out = '0;
    obs_p   = '0;
    obs_e   = '0;
    n_cyc   = 0;
    n_start = 0;
  endtask

  task automatic rec();
    obs_out = {obs_out[62:0], bus.s_out};
    obs_p   = {obs_p[62:0], bus.pause};
    obs_e   = {obs_e[62:0], bus.endr_s};
    n_cyc++;
    if (bus.start_s) n_start++;
  endtask

  // Present one item; if the stuffer is pausing, keep it on the inputs
  // until it is actually taken.
  task automatic step(input logic b, input logic st, input logic en);
    int   guard;
    logic p;
    bus.s_in    = b;
    bus.start_b = st;
    bus.endr_b  = en;
    guard = 0;
    do begin
      p = bus.pause;
      @(posedge clk);
      #1;
      rec();
      guard++;
    end while (p && guard < 4);
    if (p) begin
      errors++;
      $display("FAIL pause_stuck observed=1 expected=0");
    end
    bus.s_in    = 1'b0;
    bus.start_b = 1'b0;
    bus.endr_b  = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) step(v[i], 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] token;

  initial begin
    rst         = 1'b1;
    bus.s_in    = 1'b0;
    bus.start_b = 1'b0;
    bus.endr_b  = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({bus.s_out, bus.start_s, bus.endr_s, bus.pause, bus.busy, bus.stuff_cnt}), 64'd0);
    rst = 1'b0;

    // IDLE ignores s_in and endr_b
    clr();
    step(1'b1, 1'b0, 1'b1);
    chk("idle_ignore", 64'({bus.s_out, bus.endr_s, bus.busy}), 64'd0);

    // Token packet: no run of six, output is input delayed one cycle
    token = 32'b00000001_10000111_0000100_0111_01101;
    clr();
    step(1'b0, 1'b1, 1'b0);
    chk("tok_start_s", 64'(bus.start_s), 64'd1);
    chk("tok_busy", 64'(bus.busy), 64'd1);
    clr();
    send_vec(64'(token), 32);
    step(1'b0, 1'b0, 1'b1);
    chk("tok_out", obs_out, {31'd0, token, 1'b0});
    chk("tok_ncyc", 64'(n_cyc), 64'd33);
    chk("tok_pause", obs_p, 64'd0);
    chk("tok_endr", obs_e, 64'd1);
    chk("tok_cnt", 64'(bus.stuff_cnt), 64'd0);
    chk("tok_busy_end", 64'(bus.busy), 64'd0);

    // 11111111 0 -> 1111110 110
    clr();
    step(1'b0, 1'b1, 1'b0);
    clr();
    send_vec(64'b111111110, 9);
    step(1'b0, 1'b0, 1'b1);
    chk("ones8_out", obs_out, 64'b11111101100);
    chk("ones8_pause", obs_p, 64'b00000100000);
    chk("ones8_endr", obs_e, 64'b00000000001);
    chk("ones8_cnt", 64'(bus.stuff_cnt), 64'd1);

    // twelve 1s then end -> 111111 0 111111 0, end
    clr();
    step(1'b0, 1'b1, 1'b0);
    clr();
    send_vec(64'hFFF, 12);
    step(1'b0, 1'b0, 1'b1);
    chk("ones12_out", obs_out, 64'b111111011111100);
    chk("ones12_pause", obs_p, 64'b000001000000100);
    chk("ones12_endr", obs_e, 64'b000000000000001);
    chk("ones12_cnt", 64'(bus.stuff_cnt), 64'd2);

    // 11111 0 11111 0 -> no insertion
    clr();
    step(1'b0, 1'b1, 1'b0);
    clr();
    send_vec(64'b111110111110, 12);
    step(1'b0, 1'b0, 1'b1);
    chk("ones5_out", obs_out, 64'b1111101111100);
    chk("ones5_pause", obs_p, 64'd0);
    chk("ones5_cnt", 64'(bus.stuff_cnt), 64'd0);

    // six 1s ending the packet; endr_b held through the pause
    clr();
    step(1'b0, 1'b1, 1'b0);
    clr();
    send_vec(64'h3F, 6);
    step(1'b0, 1'b0, 1'b1);
    chk("tail_out", obs_out, 64'b11111100);
    chk("tail_pause", obs_p, 64'b00000100);
    chk("tail_endr", obs_e, 64'b00000001);
    chk("tail_cnt", 64'(bus.stuff_cnt), 64'd1);

    // restart in RUN (with coincident endr_b) after a stuffed packet
    clr();
    step(1'b0, 1'b1, 1'b0);
    send_vec(64'h3FF, 10);
    chk("abort_pre_cnt", 64'(bus.stuff_cnt), 64'd1);
    clr();
    step(1'b0, 1'b1, 1'b1);
    chk("abort_start_s", 64'(n_start), 64'd1);
    chk("abort_no_endr", obs_e, 64'd0);
    chk("abort_cnt", 64'(bus.stuff_cnt), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd1);
    clr();
    send_vec(64'b110, 3);
    step(1'b0, 1'b0, 1'b1);
    chk("abort_run_cleared", obs_p, 64'd0);
    chk("abort_out", obs_out, 64'b1100);
    chk("abort_endr", obs_e, 64'b0001);

    // reset during RUN after three bits
    clr();
    step(1'b0, 1'b1, 1'b0);
    send_vec(64'b111, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outs", 64'({bus.s_out, bus.start_s, bus.endr_s, bus.pause, bus.busy, bus.stuff_cnt}), 64'd0);
    rst = 1'b0;
    clr();
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_no_endr", obs_e, 64'd0);
    clr();
    step(1'b0, 1'b1, 1'b0);
    chk("midrst_restart", 64'({bus.start_s, bus.busy}), 64'b11);
    step(1'b0, 1'b0, 1'b1);
    chk("midrst_endr", 64'({bus.endr_s, bus.busy}), 64'b10);

    // statistics counter saturates instead of wrapping (260 stuffs)
    clr();
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 260 * 6; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_cnt", 64'(bus.stuff_cnt), 64'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
